// File: rtl/enemy_patrol_array.sv
// Patrol controller for NUM_ENEMIES walkers on a shared tile map, with stomp/hit detection against Mario.
// Optional feature: define ENEMY_GRAVITY_EN to let unsupported enemies fall until they land or drop off-screen.
module enemy_patrol_array #(
  parameter int NUM_ENEMIES     = 4,
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40,
  parameter int ROWS            = 12,
  parameter int COLS            = 17,
  parameter int BLK             = 2,
  parameter int GND             = 3,
  parameter int SPEED           = 1,
  parameter int OFFSCREEN_X     = 1000
) (
  input  logic                              movement_clock,
  input  logic                              reset,
  input  logic [ROWS-1:0][COLS-1:0][7:0]    background,
  input  logic signed [31:0]                mario_x,
  input  logic signed [31:0]                mario_y,
  input  logic signed [31:0]                spawn_x [NUM_ENEMIES],
  input  logic signed [31:0]                spawn_y [NUM_ENEMIES],
  input  logic [NUM_ENEMIES-1:0]            spawn_en,
  output logic signed [31:0]                enemy_x [NUM_ENEMIES],
  output logic signed [31:0]                enemy_y [NUM_ENEMIES],
  output logic [NUM_ENEMIES-1:0]            alive,
  output logic                              lose,
  output logic [7:0]                        stomp_count
);

  localparam int CW    = CHARACTER_WIDTH;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int X_MAX = SCREEN_WIDTH - CHARACTER_WIDTH;

  typedef enum logic [1:0] {SPAWN, LEFT, RIGHT, DEAD} slot_state_t;

  slot_state_t              state_q [NUM_ENEMIES];
  slot_state_t              state_d [NUM_ENEMIES];
  logic signed [31:0]       x_d     [NUM_ENEMIES];
  logic signed [31:0]       y_d     [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0]   alive_d;
  logic                     lose_d;
  logic [7:0]               stomp_count_d;

  // Pixel to tile index; negative pixels map to tile 0, overshoot clamps to the last tile.
  function automatic logic [RW-1:0] row_idx(input logic signed [31:0] v);
    logic signed [31:0] q;
    q = (v < 0) ? 32'sd0 : v / BLOCK_WIDTH;
    if (q > ROWS - 1) q = ROWS - 1;
    return RW'(q);
  endfunction

  function automatic logic [CLW-1:0] col_idx(input logic signed [31:0] v);
    logic signed [31:0] q;
    q = (v < 0) ? 32'sd0 : v / BLOCK_WIDTH;
    if (q > COLS - 1) q = COLS - 1;
    return CLW'(q);
  endfunction

  function automatic logic signed [31:0] clamp_x(input logic signed [31:0] v);
    if (v < 0)     return 32'sd0;
    if (v > X_MAX) return X_MAX;
    return v;
  endfunction

  function automatic logic [7:0] sat_count(input logic [7:0] c, input int k);
    int s;
    s = int'({24'd0, c}) + k;
    return (s > 255) ? 8'd255 : s[7:0];
  endfunction

  function automatic logic is_blk(input logic [7:0] t);
    return t == 8'(BLK);
  endfunction

  function automatic logic is_floor(input logic [7:0] t);
    return (t == 8'(BLK)) || (t == 8'(GND));
  endfunction

  function automatic logic below_screen(input logic signed [31:0] y);
    return y + CW >= SCREEN_HEIGHT;
  endfunction

  // Next-state decode: every slot sees the pre-edge positions and the pre-edge lose flag.
  always_comb begin
    logic signed [31:0] ex;
    logic signed [31:0] ey;
    logic               overlap;
    logic               stomp;
    logic               hit;
    logic               at_edge;
    logic               wall_tile;
    logic [RW-1:0]      r_top;
    logic [RW-1:0]      r_bot;
    logic [CLW-1:0]     c_wall;
    int                 stomp_total;
`ifdef ENEMY_GRAVITY_EN
    logic [RW-1:0]      r_floor;
    logic               supported;
`endif
    lose_d      = lose;
    alive_d     = alive;
    stomp_total = 0;
    ex          = '0;
    ey          = '0;
    overlap     = 1'b0;
    stomp       = 1'b0;
    hit         = 1'b0;
    at_edge     = 1'b0;
    wall_tile   = 1'b0;
    r_top       = '0;
    r_bot       = '0;
    c_wall      = '0;
`ifdef ENEMY_GRAVITY_EN
    r_floor     = '0;
    supported   = 1'b0;
`endif
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = enemy_x[i];
      y_d[i]     = enemy_y[i];
      ex         = enemy_x[i];
      ey         = enemy_y[i];
      overlap    = (mario_x + CW >= ex) && (mario_x <= ex + CW);
      stomp      = overlap && (mario_y + CW == ey);
      hit        = overlap && (mario_y + CW > ey) && (mario_y < ey + CW);
      r_top      = row_idx(ey);
      r_bot      = row_idx(ey + CW - 1);
      c_wall     = (state_q[i] == RIGHT) ? col_idx(ex + CW + 1) : col_idx(ex - 1);
      wall_tile  = is_blk(background[r_top][c_wall]) || is_blk(background[r_bot][c_wall]);
      at_edge    = (state_q[i] == RIGHT) ? (ex + CW + SPEED >= SCREEN_WIDTH) : (ex - SPEED <= 0);
`ifdef ENEMY_GRAVITY_EN
      r_floor    = row_idx(ey + CW);
      supported  = is_floor(background[r_floor][col_idx(ex)]) ||
                   is_floor(background[r_floor][col_idx(ex + CW - 1)]);
`endif
      if (!lose) begin
        case (state_q[i])
          SPAWN: begin
            if (spawn_en[i]) begin
              state_d[i] = RIGHT;
              x_d[i]     = spawn_x[i];
              y_d[i]     = spawn_y[i];
              alive_d[i] = 1'b1;
            end else begin
              state_d[i] = DEAD;
              x_d[i]     = OFFSCREEN_X;
            end
          end
          LEFT, RIGHT: begin
            if (stomp) begin
              state_d[i]  = DEAD;
              x_d[i]      = OFFSCREEN_X;
              alive_d[i]  = 1'b0;
              stomp_total = stomp_total + 1;
            end else if (hit) begin
              lose_d = 1'b1;
`ifdef ENEMY_GRAVITY_EN
            end else if (!supported) begin
              if (below_screen(ey)) begin
                state_d[i] = DEAD;
                x_d[i]     = OFFSCREEN_X;
                alive_d[i] = 1'b0;
              end else begin
                y_d[i] = ey + SPEED;
              end
`endif
            end else if (wall_tile || at_edge) begin
              // Reversal tick: direction flips, position holds.
              state_d[i] = (state_q[i] == RIGHT) ? LEFT : RIGHT;
            end else begin
              x_d[i] = clamp_x((state_q[i] == RIGHT) ? ex + SPEED : ex - SPEED);
            end
          end
          default: ;
        endcase
      end
    end
    stomp_count_d = sat_count(stomp_count, stomp_total);
  end

  // State register: lose doubles as the global freeze, so only reset can leave it.
  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i] <= SPAWN;
        enemy_x[i] <= OFFSCREEN_X;
        enemy_y[i] <= '0;
      end
      alive       <= '0;
      lose        <= 1'b0;
      stomp_count <= '0;
    end else begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i] <= state_d[i];
        enemy_x[i] <= x_d[i];
        enemy_y[i] <= y_d[i];
      end
      alive       <= alive_d;
      lose        <= lose_d;
      stomp_count <= stomp_count_d;
    end
  end

endmodule

// File: tb/tb_enemy_patrol_array.sv
// Scoreboard bench for enemy_patrol_array: expected per-tick snapshots are queued, then popped after each edge.
module tb_enemy_patrol_array;
  localparam int N = 4;

  logic                         movement_clock = 1'b0;
  logic                         reset = 1'b1;
  logic [11:0][16:0][7:0]       background;
  logic signed [31:0]           mario_x, mario_y;
  logic signed [31:0]           spawn_x [N];
  logic signed [31:0]           spawn_y [N];
  logic [N-1:0]                 spawn_en;
  logic signed [31:0]           enemy_x [N];
  logic signed [31:0]           enemy_y [N];
  logic [N-1:0]                 alive;
  logic                         lose;
  logic [7:0]                   stomp_count;

  typedef struct {
    int         x0;
    int         x1;
    int         y0;
    logic [3:0] al;
    logic       lo;
    int         cnt;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  enemy_patrol_array dut (
    .movement_clock (movement_clock),
    .reset          (reset),
    .background     (background),
    .mario_x        (mario_x),
    .mario_y        (mario_y),
    .spawn_x        (spawn_x),
    .spawn_y        (spawn_y),
    .spawn_en       (spawn_en),
    .enemy_x        (enemy_x),
    .enemy_y        (enemy_y),
    .alive          (alive),
    .lose           (lose),
    .stomp_count    (stomp_count)
  );

  always #5 movement_clock = ~movement_clock;

  function automatic exp_t mk(input int x0, input int x1, input int y0,
                              input logic [3:0] al, input logic lo, input int cnt);
    exp_t e;
    e.x0 = x0; e.x1 = x1; e.y0 = y0; e.al = al; e.lo = lo; e.cnt = cnt;
    return e;
  endfunction

  task automatic tick;
    @(posedge movement_clock);
    #1;
  endtask

  task automatic open_map;
    background = '0;
    for (int c = 0; c < 17; c++) background[4'd11][5'(c)] = 8'd3;
  endtask

  task automatic start_game(input logic [3:0] en, input int x0, input int y0,
                            input int x1, input int y1);
    reset    = 1'b0;
    mario_x  = 2000;
    mario_y  = 0;
    spawn_en = en;
    spawn_x[0] = x0; spawn_y[0] = y0;
    spawn_x[1] = x1; spawn_y[1] = y1;
    spawn_x[2] = 500; spawn_y[2] = 398;
    spawn_x[3] = 560; spawn_y[3] = 398;
    #1;
    @(negedge movement_clock);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    exp_t e;
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk(1000, 1000, 0, 4'b0000, 1'b0, 0));
    e = sb.pop_front();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (enemy_x[i] !== e.x0) begin n_bad++; $display("FAIL reset_x[%0d]: got %0d want %0d", i, enemy_x[i], e.x0); end
      n_cmp++;
      if (enemy_y[i] !== e.y0) begin n_bad++; $display("FAIL reset_y[%0d]: got %0d want %0d", i, enemy_y[i], e.y0); end
    end
    n_cmp++; if (alive !== e.al) begin n_bad++; $display("FAIL reset_alive: got %b want %b", alive, e.al); end
    n_cmp++; if (lose !== e.lo) begin n_bad++; $display("FAIL reset_lose: got %b want %b", lose, e.lo); end
    n_cmp++; if (stomp_count !== 8'(e.cnt)) begin n_bad++; $display("FAIL reset_count: got %0d want %0d", stomp_count, e.cnt); end
  endtask

  task automatic test_spawn_walk;
    exp_t e;
    open_map();
    start_game(4'b0011, 100, 398, 300, 398);
    for (int t = 1; t <= 6; t++) sb.push_back(mk(100 + t - 1, 300 + t - 1, 398, 4'b0011, 1'b0, 0));
    for (int t = 1; sb.size() > 0; t++) begin
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL walk_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (enemy_x[1] !== e.x1) begin n_bad++; $display("FAIL walk_x1 t%0d: got %0d want %0d", t, enemy_x[1], e.x1); end
      n_cmp++; if (enemy_y[0] !== e.y0) begin n_bad++; $display("FAIL walk_y0 t%0d: got %0d want %0d", t, enemy_y[0], e.y0); end
      n_cmp++; if (alive !== e.al) begin n_bad++; $display("FAIL walk_alive t%0d: got %b want %b", t, alive, e.al); end
      n_cmp++; if (enemy_x[2] !== 1000 || enemy_x[3] !== 1000) begin
        n_bad++; $display("FAIL walk_parked t%0d: got %0d/%0d want 1000/1000", t, enemy_x[2], enemy_x[3]);
      end
    end
  endtask

  task automatic test_wall_right;
    exp_t e;
    int seq [11] = '{150, 151, 152, 153, 154, 155, 156, 157, 157, 156, 155};
    open_map();
    background[4'd9][5'd5] = 8'd2;
    start_game(4'b0001, 150, 398, 0, 0);
    for (int k = 0; k < 11; k++) sb.push_back(mk(seq[k], 1000, 398, 4'b0001, 1'b0, 0));
    for (int t = 1; sb.size() > 0; t++) begin
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL wallr_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (enemy_x[1] !== e.x1) begin n_bad++; $display("FAIL wallr_x1 t%0d: got %0d want %0d", t, enemy_x[1], e.x1); end
      n_cmp++; if (alive !== e.al) begin n_bad++; $display("FAIL wallr_alive t%0d: got %b want %b", t, alive, e.al); end
    end
  endtask

  task automatic test_wall_left;
    exp_t e;
    int seq [9] = '{3, 3, 2, 1, 1, 1, 1, 1, 1};
    open_map();
    background[4'd9][5'd1] = 8'd2;
    start_game(4'b0001, 3, 398, 0, 0);
    for (int k = 0; k < 9; k++) sb.push_back(mk(seq[k], 1000, 398, 4'b0001, 1'b0, 0));
    for (int t = 1; sb.size() > 0; t++) begin
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL walll_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (enemy_y[0] !== e.y0) begin n_bad++; $display("FAIL walll_y0 t%0d: got %0d want %0d", t, enemy_y[0], e.y0); end
    end
  endtask

  task automatic test_stomp;
    exp_t e;
    open_map();
    start_game(4'b0001, 100, 398, 0, 0);
    sb.push_back(mk(100, 1000, 398, 4'b0001, 1'b0, 0));
    for (int k = 0; k < 3; k++) sb.push_back(mk(1000, 1000, 398, 4'b0000, 1'b0, 1));
    for (int t = 1; sb.size() > 0; t++) begin
      if (t == 2) begin mario_x = 120; mario_y = 356; end
      if (t == 3) begin mario_x = 2000; mario_y = 0; end
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL stomp_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (alive !== e.al) begin n_bad++; $display("FAIL stomp_alive t%0d: got %b want %b", t, alive, e.al); end
      n_cmp++; if (lose !== e.lo) begin n_bad++; $display("FAIL stomp_lose t%0d: got %b want %b", t, lose, e.lo); end
      n_cmp++; if (stomp_count !== 8'(e.cnt)) begin n_bad++; $display("FAIL stomp_count t%0d: got %0d want %0d", t, stomp_count, e.cnt); end
    end
  endtask

  task automatic test_double_stomp;
    exp_t e;
    open_map();
    start_game(4'b0011, 100, 398, 120, 398);
    sb.push_back(mk(100, 120, 398, 4'b0011, 1'b0, 0));
    sb.push_back(mk(1000, 1000, 398, 4'b0000, 1'b0, 2));
    for (int t = 1; sb.size() > 0; t++) begin
      if (t == 2) begin mario_x = 120; mario_y = 356; end
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL dstomp_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (enemy_x[1] !== e.x1) begin n_bad++; $display("FAIL dstomp_x1 t%0d: got %0d want %0d", t, enemy_x[1], e.x1); end
      n_cmp++; if (alive !== e.al) begin n_bad++; $display("FAIL dstomp_alive t%0d: got %b want %b", t, alive, e.al); end
      n_cmp++; if (stomp_count !== 8'(e.cnt)) begin n_bad++; $display("FAIL dstomp_count t%0d: got %0d want %0d", t, stomp_count, e.cnt); end
    end
  endtask

  task automatic test_stomp_and_hit;
    exp_t e;
    open_map();
    start_game(4'b0011, 100, 398, 100, 380);
    sb.push_back(mk(100, 100, 398, 4'b0011, 1'b0, 0));
    for (int k = 0; k < 3; k++) sb.push_back(mk(1000, 100, 398, 4'b0010, 1'b1, 1));
    for (int t = 1; sb.size() > 0; t++) begin
      if (t == 2) begin mario_x = 120; mario_y = 356; end
      if (t == 3) begin mario_x = 2000; mario_y = 0; end
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL sh_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (enemy_x[1] !== e.x1) begin n_bad++; $display("FAIL sh_x1 t%0d: got %0d want %0d", t, enemy_x[1], e.x1); end
      n_cmp++; if (alive !== e.al) begin n_bad++; $display("FAIL sh_alive t%0d: got %b want %b", t, alive, e.al); end
      n_cmp++; if (lose !== e.lo) begin n_bad++; $display("FAIL sh_lose t%0d: got %b want %b", t, lose, e.lo); end
      n_cmp++; if (stomp_count !== 8'(e.cnt)) begin n_bad++; $display("FAIL sh_count t%0d: got %0d want %0d", t, stomp_count, e.cnt); end
    end
  endtask

  task automatic test_hit_freeze;
    exp_t e;
    open_map();
    start_game(4'b0011, 100, 398, 300, 398);
    sb.push_back(mk(100, 300, 398, 4'b0011, 1'b0, 0));
    for (int k = 0; k < 11; k++) sb.push_back(mk(100, 301, 398, 4'b0011, 1'b1, 0));
    for (int t = 1; sb.size() > 0; t++) begin
      if (t == 2) begin mario_x = 120; mario_y = 360; end
      if (t == 3) begin mario_x = 2000; mario_y = 0; end
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL hit_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (enemy_x[1] !== e.x1) begin n_bad++; $display("FAIL hit_x1 t%0d: got %0d want %0d", t, enemy_x[1], e.x1); end
      n_cmp++; if (lose !== e.lo) begin n_bad++; $display("FAIL hit_lose t%0d: got %b want %b", t, lose, e.lo); end
    end
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk(1000, 1000, 0, 4'b0000, 1'b0, 0));
    e = sb.pop_front();
    n_cmp++; if (lose !== e.lo) begin n_bad++; $display("FAIL hit_reset_lose: got %b want %b", lose, e.lo); end
    n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL hit_reset_x0: got %0d want %0d", enemy_x[0], e.x0); end
    n_cmp++; if (enemy_x[1] !== e.x1) begin n_bad++; $display("FAIL hit_reset_x1: got %0d want %0d", enemy_x[1], e.x1); end
    n_cmp++; if (alive !== e.al) begin n_bad++; $display("FAIL hit_reset_alive: got %b want %b", alive, e.al); end
  endtask

`ifdef ENEMY_GRAVITY_EN
  task automatic test_gravity;
    exp_t e;
    open_map();
    start_game(4'b0001, 100, 200, 0, 0);
    for (int t = 1; t <= 201; t++) begin
      if (t <= 199) sb.push_back(mk(100, 1000, 200 + t - 1, 4'b0001, 1'b0, 0));
      else          sb.push_back(mk(100 + t - 199, 1000, 398, 4'b0001, 1'b0, 0));
    end
    for (int t = 1; sb.size() > 0; t++) begin
      tick();
      e = sb.pop_front();
      n_cmp++; if (enemy_x[0] !== e.x0) begin n_bad++; $display("FAIL grav_x0 t%0d: got %0d want %0d", t, enemy_x[0], e.x0); end
      n_cmp++; if (enemy_y[0] !== e.y0) begin n_bad++; $display("FAIL grav_y0 t%0d: got %0d want %0d", t, enemy_y[0], e.y0); end
    end
  endtask
`endif

  initial begin
    background = '0;
    mario_x    = 2000;
    mario_y    = 0;
    spawn_en   = '0;
    for (int i = 0; i < N; i++) begin
      spawn_x[i] = 0;
      spawn_y[i] = 0;
    end
    test_reset();
    test_spawn_walk();
    test_wall_right();
    test_wall_left();
    test_stomp();
    test_double_stomp();
    test_stomp_and_hit();
    test_hit_freeze();
`ifdef ENEMY_GRAVITY_EN
    test_gravity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
